// File: rtl/round_pkg.sv
// Shared constants and helpers for the round controller.
// State codes, count width and the absolute-error function.
package round_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] ERR_SAT = 8'd127;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    // |d| of a signed byte; -128 has no positive twin so it clips
    function automatic logic [CNT_W-1:0] abs_err(input logic [CNT_W-1:0] d);
        if (d == 8'h80)
            return ERR_SAT;
        else if (d[CNT_W-1])
            return ~d + 8'd1;
        else
            return d;
    endfunction

endpackage

// File: rtl/round_ctrl_tick_prescaler.sv
// 1 ms tick enable derived from Clk100M.
// Restarts from zero whenever clr is asserted.
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic Clk100M,
    input  logic Rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer: arm countdown, counting window, score capture.
// Tracks the best absolute error seen since reset.
module round_ctrl
    import round_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int ARM_MS   = 3000,
    parameter int ROUND_MS = 10000
) (
    input  logic       Clk100M,
    input  logic       Rst_n,
    input  logic       go,
    input  logic       abort,
    input  logic       user_tick,
    input  logic       symbol_tick,
    input  logic [7:0] score_diff,
    output logic       score_start,
    output logic       score_stop,
    output logic [7:0] user_count,
    output logic [7:0] magic_count,
    output logic [7:0] result,
    output logic       result_valid,
    input  logic       result_ack,
    output logic [7:0] best_err,
    output logic       busy
);

    localparam int MS_MAX = (ARM_MS > ROUND_MS) ? ARM_MS : ROUND_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    logic [2:0]      state;
    logic [2:0]      nxt;
    logic [MS_W-1:0] ms_cnt;
    logic            settle_cnt;
    logic            tick;
    logic            arm_done;
    logic            run_done;
    logic [7:0]      err;

    assign arm_done = tick && (ms_cnt == MS_W'(ARM_MS - 1));
    assign run_done = tick && (ms_cnt == MS_W'(ROUND_MS - 1));
    assign err      = abs_err(score_diff);
    assign busy     = (state != S_IDLE);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .Clk100M(Clk100M),
        .Rst_n  (Rst_n),
        .clr    (nxt != state),
        .tick   (tick)
    );

    // abort is checked before the tick boundary so it always wins
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (go) nxt = S_ARM;
            S_ARM:    if (abort) nxt = S_IDLE;
                      else if (arm_done) nxt = S_RUN;
            S_RUN:    if (abort) nxt = S_IDLE;
                      else if (run_done) nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt) nxt = S_REPORT;
            S_REPORT: if (result_ack) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= S_IDLE;
            ms_cnt       <= '0;
            settle_cnt   <= 1'b0;
            score_start  <= 1'b0;
            score_stop   <= 1'b0;
            user_count   <= '0;
            magic_count  <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            best_err     <= CNT_MAX;
        end else begin
            state       <= nxt;
            score_start <= (state == S_ARM) && (nxt == S_RUN);
            score_stop  <= ((state == S_ARM || state == S_RUN) && nxt == S_IDLE)
                         || (state == S_RUN && nxt == S_SETTLE);

            if (nxt != state)
                ms_cnt <= '0;
            else if (tick)
                ms_cnt <= ms_cnt + 1'b1;

            settle_cnt <= (state == S_SETTLE) ? ~settle_cnt : 1'b0;

            if (state == S_IDLE && go) begin
                user_count  <= '0;
                magic_count <= '0;
            end else if (state == S_RUN && !abort) begin
                if (user_tick && user_count != CNT_MAX)
                    user_count <= user_count + 1'b1;
                if (symbol_tick && magic_count != CNT_MAX)
                    magic_count <= magic_count + 1'b1;
            end

            if (state == S_SETTLE && nxt == S_REPORT) begin
                result       <= score_diff;
                result_valid <= 1'b1;
                if (err < best_err)
                    best_err <= err;
            end else if (state == S_REPORT && nxt == S_IDLE) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: directed round table, random rounds
// against a round-level reference model, and reset corner cases.
module tb_round_ctrl;

    localparam int TD     = 4;
    localparam int AM     = 2;
    localparam int RM     = 10;
    localparam int RM_SAT = 100;
    localparam int MAXLEN = RM_SAT * TD;

    logic Clk100M = 1'b0;
    logic Rst_n = 1'b0;
    logic go = 1'b0, abort = 1'b0, result_ack = 1'b0;
    logic user_tick = 1'b0, symbol_tick = 1'b0;
    logic sel = 1'b0;
    logic [7:0] diff_a = '0, diff_b = '0;

    logic a_start, a_stop, a_valid, a_busy;
    logic b_start, b_stop, b_valid, b_busy;
    logic [7:0] a_user, a_magic, a_result, a_best;
    logic [7:0] b_user, b_magic, b_result, b_best;

    logic o_start, o_stop, o_valid, o_busy;
    logic [7:0] o_user, o_magic, o_result, o_best;

    int ncmp = 0;
    int nerr = 0;
    int best_m[2] = '{255, 255};
    bit ub[MAXLEN];
    bit sb[MAXLEN];

    always #5 Clk100M = ~Clk100M;

    round_ctrl #(.TICK_DIV(TD), .ARM_MS(AM), .ROUND_MS(RM)) u_dut (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .go(go & ~sel), .abort(abort),
        .user_tick(user_tick), .symbol_tick(symbol_tick),
        .score_diff(diff_a), .score_start(a_start), .score_stop(a_stop),
        .user_count(a_user), .magic_count(a_magic), .result(a_result),
        .result_valid(a_valid), .result_ack(result_ack),
        .best_err(a_best), .busy(a_busy)
    );

    round_ctrl #(.TICK_DIV(TD), .ARM_MS(AM), .ROUND_MS(RM_SAT)) u_sat (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .go(go & sel), .abort(abort),
        .user_tick(user_tick), .symbol_tick(symbol_tick),
        .score_diff(diff_b), .score_start(b_start), .score_stop(b_stop),
        .user_count(b_user), .magic_count(b_magic), .result(b_result),
        .result_valid(b_valid), .result_ack(result_ack),
        .best_err(b_best), .busy(b_busy)
    );

    // score unit model: latches magic minus user on the stop pulse
    always @(posedge Clk100M) begin
        if (a_stop) diff_a <= a_magic - a_user;
        if (b_stop) diff_b <= b_magic - b_user;
    end

    assign o_start  = sel ? b_start  : a_start;
    assign o_stop   = sel ? b_stop   : a_stop;
    assign o_valid  = sel ? b_valid  : a_valid;
    assign o_busy   = sel ? b_busy   : a_busy;
    assign o_user   = sel ? b_user   : a_user;
    assign o_magic  = sel ? b_magic  : a_magic;
    assign o_result = sel ? b_result : a_result;
    assign o_best   = sel ? b_best   : a_best;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk100M);
        #1;
    endtask

    task automatic run_round(input bit s, input int abort_at,
                             input bit noise, output logic [7:0] r_res,
                             output logic [7:0] r_u, output logic [7:0] r_m);
        int run_len;
        int eu, em, e, k;
        logic [7:0] er;
        run_len = (s ? RM_SAT : RM) * TD;
        sel = s;
        eu = 0;
        em = 0;
        for (int i = 0; i < run_len; i++) begin
            eu += int'(ub[i]);
            em += int'(sb[i]);
        end
        if (eu > 255) eu = 255;
        if (em > 255) em = 255;
        er = 8'(em - eu);
        e = int'($signed(er));
        if (e < 0) e = -e;
        if (e > 127) e = 127;
        r_res = '0;
        r_u = '0;
        r_m = '0;

        go = 1'b1;
        step();
        go = 1'b0;
        chk("busy_arm", o_busy, 1);
        chk("cnt_clr", {o_user, o_magic}, 0);
        user_tick = 1'b1;
        symbol_tick = 1'b1;
        k = 0;
        while (!o_start && k < 100) begin
            step();
            k++;
        end
        chk("arm_len", k, AM * TD);

        for (int i = 0; i < run_len; i++) begin
            user_tick = ub[i];
            symbol_tick = sb[i];
            abort = (i == abort_at);
            go = noise && (i % 7 == 3);
            if (i == 1) chk("start_1cyc", o_start, 0);
            step();
            if (i == abort_at) break;
        end
        user_tick = 1'b0;
        symbol_tick = 1'b0;
        abort = 1'b0;
        go = 1'b0;

        if (abort_at >= 0) begin
            chk("abort_stop", o_stop, 1);
            chk("abort_idle", o_busy, 0);
            chk("abort_nostart", o_start, 0);
            step();
            chk("abort_stop_1cyc", o_stop, 0);
            chk("abort_novalid", o_valid, 0);
            chk("abort_best", o_best, best_m[s]);
            return;
        end

        chk("stop", o_stop, 1);
        chk("stop_nostart", o_start, 0);
        chk("user_cnt", o_user, eu);
        chk("magic_cnt", o_magic, em);
        abort = 1'b1;
        user_tick = 1'b1;
        symbol_tick = 1'b1;
        step();
        abort = 1'b0;
        chk("stop_1cyc", o_stop, 0);
        chk("settle_busy", o_busy, 1);
        chk("settle_novalid", o_valid, 0);
        step();
        user_tick = 1'b0;
        symbol_tick = 1'b0;
        chk("valid", o_valid, 1);
        chk("result", o_result, er);
        chk("cnt_frozen", {o_user, o_magic}, {eu[7:0], em[7:0]});
        if (e < best_m[s]) best_m[s] = e;
        chk("best_err", o_best, best_m[s]);
        for (int i = 0; i < 3; i++) begin
            go = 1'b1;
            abort = (i == 1);
            step();
            go = 1'b0;
            abort = 1'b0;
            chk("valid_held", o_valid, 1);
        end
        result_ack = 1'b1;
        go = 1'b1;
        step();
        result_ack = 1'b0;
        go = 1'b0;
        chk("ack_clr", o_valid, 0);
        chk("ack_idle", o_busy, 0);
        step();
        chk("go_with_ack_ignored", o_busy, 0);
        r_res = o_result;
        r_u = o_user;
        r_m = o_magic;
    endtask

    typedef struct {
        bit s;
        int uoff, nu, soff, ns;
        int abort_at;
        bit noise;
        int x_u, x_m, x_res, x_best;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] rr, ru, rm;
        int k;

        tbl[0] = '{0, 0, 5, 10, 7, -1, 0, 5, 7, 2, 2};
        tbl[1] = '{0, 0, 8, 0, 8, 20, 0, -1, -1, -1, 2};
        tbl[2] = '{0, 0, 3, 5, 7, -1, 1, 3, 7, 4, 2};
        tbl[3] = '{0, 30, 10, 30, 10, -1, 0, 10, 10, 0, 0};
        tbl[4] = '{0, 0, 40, 0, 0, 39, 0, -1, -1, -1, 0};
        tbl[5] = '{1, 0, 0, 0, 300, -1, 0, 0, 255, 255, 1};

        #22;
        chk("rst_busy", a_busy, 0);
        chk("rst_cnts", {a_user, a_magic}, 0);
        chk("rst_result", {a_result, 7'd0, a_valid}, 0);
        chk("rst_pulses", {a_start, a_stop}, 0);
        chk("rst_best", a_best, 255);
        @(negedge Clk100M);
        Rst_n = 1'b1;
        step();

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < MAXLEN; i++) begin
                ub[i] = (i >= tbl[t].uoff) && (i < tbl[t].uoff + tbl[t].nu);
                sb[i] = (i >= tbl[t].soff) && (i < tbl[t].soff + tbl[t].ns);
            end
            run_round(tbl[t].s, tbl[t].abort_at, tbl[t].noise, rr, ru, rm);
            if (tbl[t].x_res >= 0) begin
                chk($sformatf("vec%0d_user", t), ru, tbl[t].x_u);
                chk($sformatf("vec%0d_magic", t), rm, tbl[t].x_m);
                chk($sformatf("vec%0d_result", t), rr, tbl[t].x_res);
            end
            chk($sformatf("vec%0d_best", t), o_best, tbl[t].x_best);
        end

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < MAXLEN; i++) begin
                ub[i] = ($urandom % 3) == 0;
                sb[i] = ($urandom % 2) == 0;
            end
            k = (($urandom % 5) == 0) ? int'($urandom % (RM * TD)) : -1;
            run_round(1'b0, k, 1'($urandom % 2), rr, ru, rm);
        end

        sel = 1'b0;
        go = 1'b1;
        step();
        go = 1'b0;
        k = 0;
        while (!a_start && k < 100) begin
            step();
            k++;
        end
        chk("rst2_arm_len", k, AM * TD);
        user_tick = 1'b1;
        for (int i = 0; i < RM * TD; i++) step();
        user_tick = 1'b0;
        chk("rst2_in_settle", a_stop, 1);
        Rst_n = 1'b0;
        #1;
        chk("rst2_busy", a_busy, 0);
        chk("rst2_cnts", {a_user, a_magic}, 0);
        chk("rst2_outs", {a_start, a_stop, a_valid}, 0);
        chk("rst2_result", a_result, 0);
        chk("rst2_best", a_best, 255);
        best_m = '{255, 255};
        step();
        Rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst2_quiet", {a_start, a_stop, a_valid, a_busy}, 0);
        end

        for (int i = 0; i < MAXLEN; i++) begin
            ub[i] = (i < 6);
            sb[i] = (i < 9);
        end
        run_round(1'b0, -1, 1'b0, rr, ru, rm);
        chk("post_rst_result", rr, 3);
        chk("post_rst_best", a_best, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
